cmp_capture_reader: RTL

Read-side companion to the team's compare-and-capture registers. On each enabled cycle where operand a is strictly greater than operand b, the block captures the pair {a, b} into a small FIFO. Downstream logic drains captured pairs through a valid/ready read port. The block sits between the comparison datapath and a consumer such as a debug/trace collector or a CPU-visible status reader.

---
 rtl/cmp_capture_reader.sv | 87 ++++++++
 1 files changed

// File: rtl/cmp_capture_reader.sv
// Captures {a, b} into a small FIFO whenever in_en & (a > b), drained through a valid/ready read port.
// Define CMP_CAPTURE_DROP_OLDEST_EN to overwrite the oldest entry instead of dropping the new one when full.
module cmp_capture_reader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_ready,
    input  logic             clr_ovf,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic push_c;
    logic pop_c;
    logic drop_c;
    logic do_wr_c;
    logic do_rd_c;

    // Status outputs decode registered state only.
    assign rd_valid = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign rd_a     = rd_valid ? mem_a[rd_ptr] : '0;
    assign rd_b     = rd_valid ? mem_b[rd_ptr] : '0;

    always_comb begin
        push_c  = in_en & (a > b);
        pop_c   = rd_valid & rd_ready;
        drop_c  = push_c & full & ~pop_c;
`ifdef CMP_CAPTURE_DROP_OLDEST_EN
        // Full push without pop evicts the head so the newest pair is kept.
        do_wr_c = push_c;
        do_rd_c = pop_c | drop_c;
`else
        do_wr_c = push_c & (~full | pop_c);
        do_rd_c = pop_c;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_wr_c) - CNT_W'(do_rd_c);
            // A new drop takes priority over a clear in the same cycle.
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem_a[wr_ptr] <= a;
            mem_b[wr_ptr] <= b;
        end
    end

endmodule
